// File: rtl/nmr_scan_sequencer.sv
// Multi-scan phase-cycling controller: runs n_scans pulse programs, stepping TX/RX phase
// through a small table and holding enable_PC low for a repetition gap between scans.
module nmr_scan_sequencer #(
    parameter int MIN_GAP   = 20,
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          n_scans,
    input  logic [31:0]          rep_delay,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [2:0]           cycle_len,
    input  logic [59:0]          tx_phase_table,
    input  logic [19:0]          rx_phase_table,
    input  logic                 pc_done,
    output logic                 enable_PC,
    output logic [14:0]          TX_phase_data,
    output logic [4:0]           RX_phase_data,
    output logic [1:0]           phase_idx,
    output logic [15:0]          scan_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [TIMEOUT_W-1:0] WD_ONE = 1;

    logic [2:0]           state_q, state_d;
    logic [15:0]          n_scans_q, n_scans_d;
    logic [31:0]          gap_q, gap_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [2:0]           len_q, len_d;
    logic [59:0]          tx_tab_q, tx_tab_d;
    logic [19:0]          rx_tab_q, rx_tab_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [31:0]          gcnt_q, gcnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [15:0]          sc_q, sc_d;
    logic [14:0]          tx_q, tx_d;
    logic [4:0]           rx_q, rx_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           idx_next;
    logic                 wd_expired;
    logic                 gap_expired;

    assign idx_next    = ({1'b0, idx_q} + 3'd1 >= len_q) ? 2'd0 : idx_q + 2'd1;
    assign wd_expired  = (tmo_q != '0) && (wd_q == tmo_q - WD_ONE);
    // GAP is one cycle short of the gap: the ARM cycle also keeps enable_PC low.
    assign gap_expired = ({1'b0, gcnt_q} + 33'd2) >= {1'b0, gap_q};

    always_comb begin
        state_d   = state_q;
        n_scans_d = n_scans_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        len_d     = len_q;
        tx_tab_d  = tx_tab_q;
        rx_tab_d  = rx_tab_q;
        wd_d      = wd_q;
        gcnt_d    = gcnt_q;
        idx_d     = idx_q;
        sc_d      = sc_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_scans_d = n_scans;
                    gap_d     = (rep_delay < 32'(MIN_GAP)) ? 32'(MIN_GAP) : rep_delay;
                    tmo_d     = timeout_cycles;
                    len_d     = (cycle_len == 3'd0) ? 3'd1 : ((cycle_len > 3'd4) ? 3'd4 : cycle_len);
                    tx_tab_d  = tx_phase_table;
                    rx_tab_d  = rx_phase_table;
                    sc_d      = 16'd0;
                    idx_d     = 2'd0;
                    err_d     = 1'b0;
                    if (n_scans != 16'd0) begin
                        state_d = S_ARM;
                        tx_d    = tx_phase_table[14:0];
                        rx_d    = rx_phase_table[4:0];
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_ARM: begin
                state_d = S_RUN;
                wd_d    = '0;
            end
            S_RUN: begin
                wd_d = wd_q + WD_ONE;
                if (pc_done || wd_expired) begin
                    state_d = S_GAP;
                    gcnt_d  = 32'd0;
                    sc_d    = sc_q + 16'd1;
                    idx_d   = idx_next;
                    if (!pc_done) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q + 32'd1;
                if (gap_expired) begin
                    if (sc_q == n_scans_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ARM;
                        tx_d    = tx_tab_q[15*int'(idx_q) +: 15];
                        rx_d    = rx_tab_q[5*int'(idx_q) +: 5];
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort beats a coincident pc_done/timeout: progress and phase outputs freeze.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            sc_d    = sc_q;
            idx_d   = idx_q;
            err_d   = err_q;
            tx_d    = tx_q;
            rx_d    = rx_q;
        end
        en_d   = (state_d == S_RUN);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_scans_q <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            len_q     <= '0;
            tx_tab_q  <= '0;
            rx_tab_q  <= '0;
            wd_q      <= '0;
            gcnt_q    <= '0;
            idx_q     <= '0;
            sc_q      <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_scans_q <= n_scans_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            len_q     <= len_d;
            tx_tab_q  <= tx_tab_d;
            rx_tab_q  <= rx_tab_d;
            wd_q      <= wd_d;
            gcnt_q    <= gcnt_d;
            idx_q     <= idx_d;
            sc_q      <= sc_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign enable_PC     = en_q;
    assign TX_phase_data = tx_q;
    assign RX_phase_data = rx_q;
    assign phase_idx     = idx_q;
    assign scan_count    = sc_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_err   = err_q;
endmodule
